hazard_fwd_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the pipelined MIPS core. Merges load-use stall detection
//  and EX-operand forwarding into one block. It keeps its own shadow pipe of in-flight destination

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/fwd_match.sv | 30 +++
 rtl/hazard_fwd_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_fwd_scoreboard.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and configuration helpers for the hazard/forwarding scoreboard.
package hazard_pkg;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned FWD_RF = 0;

  typedef logic [TAG_W-1:0] tag_t;

  // One in-flight instruction as seen by the shadow pipe.
  typedef struct packed {
    logic valid;
    logic wr;
    logic load;
    tag_t dest;
  } shadow_entry_t;

  // Source operands of the instruction currently in EX (stage 0 only).
  typedef struct packed {
    tag_t rs;
    tag_t rt;
    logic use_rs;
    logic use_rt;
  } ex_src_t;

  function automatic bit cfg_legal(int unsigned reg_aw, int unsigned depth,
                                   int unsigned load_lat);
    return (reg_aw >= 1) && (reg_aw <= TAG_W) && (depth >= load_lat + 2);
  endfunction

  function automatic int unsigned idx_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority encoder: youngest (lowest index) shadow stage writing the given tag.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IDX_W = idx_w(DEPTH)
) (
  input  tag_t                        tag_i,
  input  shadow_entry_t [DEPTH-1:0]   stages_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic                        is_load_o
);

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (stages_i[k].valid && stages_i[k].wr &&
          (stages_i[k].dest == tag_i) && (tag_i != '0)) begin
        hit_o     = 1'b1;
        idx_o     = IDX_W'(k);
        is_load_o = stages_i[k].load;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Load-use stall detection and EX operand forwarding driven by a shadow pipe
// of in-flight destination tags.
module hazard_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SEL_W    = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic              id_kill_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              id_wr_i,
  input  logic              id_load_i,
  input  logic              hold_i,
  output logic              pc_write_o,
  output logic              ir_write_o,
  output logic              ex_bubble_o,
  output logic [SEL_W-1:0]  fwd_sel_a_o,
  output logic [SEL_W-1:0]  fwd_sel_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  if (!cfg_legal(REG_AW, DEPTH, LOAD_LAT)) begin : g_cfg_check
    $error("hazard_fwd_scoreboard: illegal REG_AW/DEPTH/LOAD_LAT combination");
  end

  shadow_entry_t [DEPTH-1:0] stages_q, stages_d, fwd_view;
  ex_src_t                   ex_src_q, ex_src_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic             fa_hit, fb_hit, srs_hit, srt_hit;
  logic [SEL_W-1:0] fa_idx, fb_idx, srs_idx, srt_idx;
  logic             srs_load, srt_load;
  logic             fa_load_unused, fb_load_unused;
  logic             stall_rs, stall_rt, issue;

  tag_t id_rs_t, id_rt_t, id_dest_t;
  assign id_rs_t   = TAG_W'(id_rs_i);
  assign id_rt_t   = TAG_W'(id_rt_i);
  assign id_dest_t = TAG_W'(id_dest_i);

  // The EX instruction must not forward from itself, so hide stage 0.
  always_comb begin
    fwd_view          = stages_q;
    fwd_view[0].valid = 1'b0;
  end

  fwd_match #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_fwd_a (
    .tag_i(ex_src_q.rs), .stages_i(fwd_view),
    .hit_o(fa_hit), .idx_o(fa_idx), .is_load_o(fa_load_unused)
  );

  fwd_match #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_fwd_b (
    .tag_i(ex_src_q.rt), .stages_i(fwd_view),
    .hit_o(fb_hit), .idx_o(fb_idx), .is_load_o(fb_load_unused)
  );

  fwd_match #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_stall_rs (
    .tag_i(id_rs_t), .stages_i(stages_q),
    .hit_o(srs_hit), .idx_o(srs_idx), .is_load_o(srs_load)
  );

  fwd_match #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_stall_rt (
    .tag_i(id_rt_t), .stages_i(stages_q),
    .hit_o(srt_hit), .idx_o(srt_idx), .is_load_o(srt_load)
  );

  // A load whose data is not yet forwardable blocks the dependent ID instruction.
  assign stall_rs = id_use_rs_i & srs_hit & srs_load & (32'(srs_idx) < LOAD_LAT);
  assign stall_rt = id_use_rt_i & srt_hit & srt_load & (32'(srt_idx) < LOAD_LAT);
  assign stall_o  = id_valid_i & ~id_kill_i & (stall_rs | stall_rt);
  assign issue    = id_valid_i & ~id_kill_i & ~stall_o;

  assign pc_write_o  = ~(stall_o | hold_i);
  assign ir_write_o  = ~(stall_o | hold_i);
  assign ex_bubble_o = stall_o | id_kill_i | ~id_valid_i;
  assign stall_cnt_o = cnt_q;

  assign fwd_sel_a_o = (stages_q[0].valid && ex_src_q.use_rs && fa_hit) ? fa_idx : SEL_W'(FWD_RF);
  assign fwd_sel_b_o = (stages_q[0].valid && ex_src_q.use_rt && fb_hit) ? fb_idx : SEL_W'(FWD_RF);

  // Shadow pipe advance and saturating stall counter.
  always_comb begin
    stages_d = stages_q;
    ex_src_d = ex_src_q;
    cnt_d    = cnt_q;
    if (!hold_i) begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        stages_d[k] = stages_q[k-1];
      end
      if (issue) begin
        stages_d[0].valid = 1'b1;
        stages_d[0].wr    = id_wr_i;
        stages_d[0].load  = id_load_i;
        stages_d[0].dest  = id_dest_t;
        ex_src_d.rs       = id_rs_t;
        ex_src_d.rt       = id_rt_t;
        ex_src_d.use_rs   = id_use_rs_i;
        ex_src_d.use_rt   = id_use_rt_i;
      end else begin
        stages_d[0] = '0;
        ex_src_d    = '0;
      end
      if (stall_o && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= '0;
      ex_src_q <= '0;
      cnt_q    <= '0;
    end else begin
      stages_q <= stages_d;
      ex_src_q <= ex_src_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard: directed table, multi-cycle sequences,
// randomized run against a per-register scoreboard model, counter saturation.
module tb_hazard_fwd_scoreboard;

  typedef struct packed {
    logic       valid;
    logic       kill;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       wr;
    logic       load;
    logic       hold;
  } id_in_t;

  typedef struct {
    id_in_t in;
    logic   st;
    logic   pcw;
    logic   bub;
    int     fa;
    int     fb;
    int     cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  id_in_t in1, in2, in3;
  logic   rst1, rst2, rst3;
  logic   pcw1, irw1, bub1, st1, pcw2, irw2, bub2, st2, pcw3, irw3, bub3, st3;
  logic [1:0]  fa1, fb1, fa2, fb2;
  logic [4:0]  fa3, fb3;
  logic [15:0] cnt1, cnt2, cnt3;

  int total = 0;
  int bad   = 0;

  hazard_fwd_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst1), .id_valid_i(in1.valid), .id_kill_i(in1.kill),
    .id_rs_i(in1.rs), .id_rt_i(in1.rt), .id_use_rs_i(in1.use_rs), .id_use_rt_i(in1.use_rt),
    .id_dest_i(in1.dest), .id_wr_i(in1.wr), .id_load_i(in1.load), .hold_i(in1.hold),
    .pc_write_o(pcw1), .ir_write_o(irw1), .ex_bubble_o(bub1), .fwd_sel_a_o(fa1),
    .fwd_sel_b_o(fb1), .stall_o(st1), .stall_cnt_o(cnt1)
  );

  hazard_fwd_scoreboard #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst2), .id_valid_i(in2.valid), .id_kill_i(in2.kill),
    .id_rs_i(in2.rs), .id_rt_i(in2.rt), .id_use_rs_i(in2.use_rs), .id_use_rt_i(in2.use_rt),
    .id_dest_i(in2.dest), .id_wr_i(in2.wr), .id_load_i(in2.load), .hold_i(in2.hold),
    .pc_write_o(pcw2), .ir_write_o(irw2), .ex_bubble_o(bub2), .fwd_sel_a_o(fa2),
    .fwd_sel_b_o(fb2), .stall_o(st2), .stall_cnt_o(cnt2)
  );

  hazard_fwd_scoreboard #(.REG_AW(5), .DEPTH(18), .LOAD_LAT(16), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst3), .id_valid_i(in3.valid), .id_kill_i(in3.kill),
    .id_rs_i(in3.rs), .id_rt_i(in3.rt), .id_use_rs_i(in3.use_rs), .id_use_rt_i(in3.use_rt),
    .id_dest_i(in3.dest), .id_wr_i(in3.wr), .id_load_i(in3.load), .hold_i(in3.hold),
    .pc_write_o(pcw3), .ir_write_o(irw3), .ex_bubble_o(bub3), .fwd_sel_a_o(fa3),
    .fwd_sel_b_o(fb3), .stall_o(st3), .stall_cnt_o(cnt3)
  );

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic id_in_t ins(bit v, bit k, int rs, int rt, bit urs, bit urt,
                                 int dest, bit wr, bit ld, bit hold);
    id_in_t r;
    r.valid = v;       r.kill = k;
    r.rs = 5'(rs);     r.rt = 5'(rt);
    r.use_rs = urs;    r.use_rt = urt;
    r.dest = 5'(dest); r.wr = wr;
    r.load = ld;       r.hold = hold;
    return r;
  endfunction

  function automatic vec_t row(id_in_t i, bit st, bit pcw, bit bub, int fa, int fb, int cnt);
    vec_t r;
    r.in = i; r.st = st; r.pcw = pcw; r.bub = bub;
    r.fa = fa; r.fb = fb; r.cnt = cnt;
    return r;
  endfunction

  // Scoreboard model for DEPTH=3, LOAD_LAT=1: per register, the age of its
  // youngest in-flight writer; EX selects are fixed when the instruction issues.
  localparam int M_D  = 3;
  localparam int M_LL = 1;
  bit m_live [32];
  bit m_ld   [32];
  int m_age  [32];
  int m_fa, m_fb, m_cnt;

  function automatic bit m_src_stall(logic [4:0] s, logic u);
    return u && (s != 0) && m_live[s] && m_ld[s] && (m_age[s] < M_LL);
  endfunction

  function automatic int m_fwd(logic [4:0] s, logic u);
    if (u && (s != 0) && m_live[s] && (m_age[s] + 1 <= M_D - 1)) return m_age[s] + 1;
    return 0;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      m_live[r] = 0; m_ld[r] = 0; m_age[r] = 0;
    end
    m_fa = 0; m_fb = 0; m_cnt = 0;
  endtask

  task automatic m_edge(id_in_t i, bit r, bit st);
    bit issue;
    int nfa, nfb;
    if (r) begin
      m_clear();
    end else if (!i.hold) begin
      if (st && m_cnt < 65535) m_cnt++;
      issue = i.valid && !i.kill && !st;
      nfa = issue ? m_fwd(i.rs, i.use_rs) : 0;
      nfb = issue ? m_fwd(i.rt, i.use_rt) : 0;
      for (int k = 0; k < 32; k++) begin
        if (m_live[k]) begin
          m_age[k]++;
          if (m_age[k] >= M_D) m_live[k] = 0;
        end
      end
      if (issue && i.wr && i.dest != 0) begin
        m_live[i.dest] = 1; m_ld[i.dest] = i.load; m_age[i.dest] = 0;
      end
      m_fa = nfa; m_fb = nfb;
    end
  endtask

  vec_t   tbl [27];
  id_in_t idle, idleh, add3, sub4, or6, lw2, add6, add6k, add6h, lw0, add5, lw4, sub7;
  id_in_t lw9, or9, lw9s;
  bit     e_st;
  int     ns;

  initial begin
    idle  = ins(0,0, 0,0, 0,0, 0,0,0,0);
    idleh = ins(0,0, 0,0, 0,0, 0,0,0,1);
    add3  = ins(1,0, 1,2, 1,1, 3,1,0,0);
    sub4  = ins(1,0, 3,5, 1,1, 4,1,0,0);
    or6   = ins(1,0, 3,3, 1,1, 6,1,0,0);
    lw2   = ins(1,0, 8,0, 1,0, 2,1,1,0);
    add6  = ins(1,0, 2,7, 1,1, 6,1,0,0);
    add6k = ins(1,1, 2,7, 1,1, 6,1,0,0);
    add6h = ins(1,0, 2,7, 1,1, 6,1,0,1);
    lw0   = ins(1,0, 8,0, 1,0, 0,1,1,0);
    add5  = ins(1,0, 0,0, 1,1, 5,1,0,0);
    lw4   = ins(1,0, 8,0, 1,0, 4,1,1,0);
    sub7  = ins(1,0, 9,4, 1,0, 7,1,0,0);
    lw9   = ins(1,0, 8,0, 1,0, 9,1,1,0);
    or9   = ins(1,0, 9,9, 1,1, 1,1,0,0);
    lw9s  = ins(1,0, 9,0, 1,0, 9,1,1,0);

    //               inputs  st pcw bub fa fb cnt
    tbl[0]  = row(idle,  0, 1, 1, 0, 0, 0);
    tbl[1]  = row(add3,  0, 1, 0, 0, 0, 0);
    tbl[2]  = row(sub4,  0, 1, 0, 0, 0, 0);
    tbl[3]  = row(or6,   0, 1, 0, 1, 0, 0);
    tbl[4]  = row(idle,  0, 1, 1, 2, 2, 0);
    tbl[5]  = row(lw2,   0, 1, 0, 0, 0, 0);
    tbl[6]  = row(add6,  1, 0, 1, 0, 0, 0);
    tbl[7]  = row(add6,  0, 1, 0, 0, 0, 1);
    tbl[8]  = row(idle,  0, 1, 1, 2, 0, 1);
    tbl[9]  = row(lw2,   0, 1, 0, 0, 0, 1);
    tbl[10] = row(add6k, 0, 1, 1, 0, 0, 1);
    tbl[11] = row(idle,  0, 1, 1, 0, 0, 1);
    tbl[12] = row(lw0,   0, 1, 0, 0, 0, 1);
    tbl[13] = row(add5,  0, 1, 0, 0, 0, 1);
    tbl[14] = row(lw4,   0, 1, 0, 0, 0, 1);
    tbl[15] = row(sub7,  0, 1, 0, 0, 0, 1);
    tbl[16] = row(idle,  0, 1, 1, 0, 0, 1);
    tbl[17] = row(lw2,   0, 1, 0, 0, 0, 1);
    tbl[18] = row(add6h, 1, 0, 1, 0, 0, 1);
    tbl[19] = row(add6h, 1, 0, 1, 0, 0, 1);
    tbl[20] = row(add6h, 1, 0, 1, 0, 0, 1);
    tbl[21] = row(add6,  1, 0, 1, 0, 0, 1);
    tbl[22] = row(add6,  0, 1, 0, 0, 0, 2);
    tbl[23] = row(idleh, 0, 0, 1, 2, 0, 2);
    tbl[24] = row(idleh, 0, 0, 1, 2, 0, 2);
    tbl[25] = row(idle,  0, 1, 1, 2, 0, 2);
    tbl[26] = row(idle,  0, 1, 1, 0, 0, 2);

    in1 = idle; in2 = idle; in3 = idle;
    rst1 = 1; rst2 = 1; rst3 = 1;
    tick(); tick();
    rst1 = 0; rst2 = 0; rst3 = 0;

    // Directed table on the default configuration.
    for (int i = 0; i < 27; i++) begin
      in1 = tbl[i].in;
      #4;
      chk($sformatf("tbl%0d_stall", i), int'(st1),   int'(tbl[i].st));
      chk($sformatf("tbl%0d_pcw", i),   int'(pcw1),  int'(tbl[i].pcw));
      chk($sformatf("tbl%0d_irw", i),   int'(irw1),  int'(tbl[i].pcw));
      chk($sformatf("tbl%0d_bub", i),   int'(bub1),  int'(tbl[i].bub));
      chk($sformatf("tbl%0d_fa", i),    int'(fa1),   tbl[i].fa);
      chk($sformatf("tbl%0d_fb", i),    int'(fb1),   tbl[i].fb);
      chk($sformatf("tbl%0d_cnt", i),   int'(cnt1),  tbl[i].cnt);
      tick();
    end

    // Reset asserted in the middle of a load-use stall.
    in1 = lw2;  tick();
    in1 = add6; #4;
    chk("rstmid_stall_before", int'(st1), 1);
    rst1 = 1; tick(); rst1 = 0; #4;
    chk("rstmid_stall_after", int'(st1), 0);
    chk("rstmid_pcw_after", int'(pcw1), 1);
    chk("rstmid_bub_after", int'(bub1), 0);
    chk("rstmid_fa_after", int'(fa1), 0);
    chk("rstmid_cnt_after", int'(cnt1), 0);
    in1 = idle; tick();

    // DEPTH=4, LOAD_LAT=2: lw r9 then or r1<-r9,r9.
    in2 = lw9; #4;
    chk("d4_lw_stall", int'(st2), 0);
    chk("d4_lw_bub", int'(bub2), 0);
    tick();
    in2 = or9; #4;
    chk("d4_stall1", int'(st2), 1);
    chk("d4_stall1_pcw", int'(pcw2), 0);
    chk("d4_stall1_irw", int'(irw2), 0);
    chk("d4_stall1_bub", int'(bub2), 1);
    tick(); #4;
    chk("d4_stall2", int'(st2), 1);
    tick(); #4;
    chk("d4_release", int'(st2), 0);
    chk("d4_release_bub", int'(bub2), 0);
    tick();
    in2 = idle; #4;
    chk("d4_fa", int'(fa2), 3);
    chk("d4_fb", int'(fb2), 3);
    chk("d4_cnt", int'(cnt2), 2);
    tick();

    // Randomized run against the scoreboard model.
    rst1 = 1; in1 = idle; tick(); rst1 = 0;
    m_clear();
    for (int c = 0; c < 800; c++) begin
      in1.valid  = ($urandom_range(0, 9) < 8);
      in1.kill   = ($urandom_range(0, 9) == 0);
      in1.rs     = 5'($urandom_range(0, 5));
      in1.rt     = 5'($urandom_range(0, 5));
      in1.use_rs = ($urandom_range(0, 9) < 8);
      in1.use_rt = ($urandom_range(0, 9) < 7);
      in1.dest   = 5'($urandom_range(0, 5));
      in1.wr     = ($urandom_range(0, 9) < 8);
      in1.load   = ($urandom_range(0, 9) < 4);
      in1.hold   = ($urandom_range(0, 9) < 2);
      rst1       = ($urandom_range(0, 63) == 0);
      #4;
      e_st = in1.valid && !in1.kill &&
             (m_src_stall(in1.rs, in1.use_rs) || m_src_stall(in1.rt, in1.use_rt));
      chk("rnd_stall", int'(st1), int'(e_st));
      chk("rnd_pcw", int'(pcw1), int'(!(e_st || in1.hold)));
      chk("rnd_irw", int'(irw1), int'(!(e_st || in1.hold)));
      chk("rnd_bub", int'(bub1), int'(e_st || in1.kill || !in1.valid));
      chk("rnd_fa", int'(fa1), m_fa);
      chk("rnd_fb", int'(fb1), m_fb);
      chk("rnd_cnt", int'(cnt1), m_cnt);
      tick();
      m_edge(in1, rst1, e_st);
    end
    rst1 = 0; in1 = idle;

    // Saturation: a self-dependent load stalls 16 of every 17 cycles.
    in3 = lw9s;
    ns  = 0;
    for (int c = 0; ns < 70000; c++) begin
      #4;
      e_st = ((c % 17) != 0);
      chk("sat_stall", int'(st3), int'(e_st));
      chk("sat_bub", int'(bub3), int'(e_st));
      chk("sat_pcw", int'(pcw3), int'(!e_st));
      chk("sat_irw", int'(irw3), int'(!e_st));
      chk("sat_fa", int'(fa3), ((c % 17) == 1 && c > 17) ? 17 : 0);
      chk("sat_fb", int'(fb3), 0);
      chk("sat_cnt", int'(cnt3), (ns > 65535) ? 65535 : ns);
      if (e_st) ns++;
      tick();
    end
    #4;
    chk("sat_final_cnt", int'(cnt3), 65535);
    in3 = idle;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
